// File: rtl/iq_window_if.sv
// Upstream instruction stream into the issue-window sequencer: valid/ready
// handshake with an 8-bit instruction and a window-close (flush) strobe.
interface iq_window_if;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_instr;
    logic       flush;

    modport master (output in_valid, output in_instr, output flush, input in_ready);
    modport slave  (input in_valid, input in_instr, input flush, output in_ready);
endinterface

// File: rtl/iq_window_ctrl.sv
// Issue-window sequencer: fills a 4-entry window from the upstream stream, builds
// the static RAW matrix, runs the scheduler until every slot retires, then clears.
module iq_window_ctrl #(
    parameter int TIMEOUT_CYC = 64,
    parameter int TO_W        = 7,
    parameter int CNT_W       = 16
) (
    input  logic              clk,
    input  logic              reset,
    iq_window_if.slave        up,
    input  logic [3:0]        retire_onehot,
    output logic              sch_enable,
    output logic              sched_reset,
    output logic [31:0]       instr_flat,
    output logic [3:0]        valid_bits,
    output logic [15:0]       raw_flat,
    output logic              busy,
    output logic              timeout_err,
    output logic [CNT_W-1:0]  windows_done
);

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        BUILD = 2'd1,
        RUN   = 2'd2,
        CLEAR = 2'd3
    } state_t;

    state_t           state_q,    state_d;
    logic [2:0]       fill_cnt_q, fill_cnt_d;
    logic [31:0]      instr_q,    instr_d;
    logic [3:0]       valid_q,    valid_d;
    logic [15:0]      raw_q,      raw_d;
    logic [3:0]       done_q,     done_d;
    logic [TO_W-1:0]  wd_q,       wd_d;
    logic             timeout_q,  timeout_d;
    logic [CNT_W-1:0] windows_q,  windows_d;

    logic       xfer;
    logic [3:0] new_ret;

    assign up.in_ready   = (state_q == FILL);
    assign sch_enable    = (state_q == RUN);
    assign sched_reset   = (state_q == CLEAR);
    assign busy          = (state_q != FILL);
    assign instr_flat    = instr_q;
    assign valid_bits    = valid_q;
    assign raw_flat      = raw_q;
    assign timeout_err   = timeout_q;
    assign windows_done  = windows_q;

    assign xfer    = up.in_valid && (state_q == FILL);
    assign new_ret = retire_onehot & valid_q;

    always_comb begin
        // NOTE: every variable gets a default first so no path can infer a latch.
        state_d    = state_q;
        fill_cnt_d = fill_cnt_q;
        instr_d    = instr_q;
        valid_d    = valid_q;
        raw_d      = raw_q;
        done_d     = done_q;
        wd_d       = wd_q;
        timeout_d  = timeout_q;
        windows_d  = windows_q;

        unique case (state_q)
            FILL: begin
                if (xfer) begin
                    instr_d[{fill_cnt_q[1:0], 3'b000} +: 8] = up.in_instr;
                    valid_d[fill_cnt_q[1:0]]                = 1'b1;
                    fill_cnt_d                              = fill_cnt_q + 3'd1;
                end
                // A flush on an empty window has nothing to close and is dropped.
                if ((xfer && fill_cnt_q == 3'd3) ||
                    (up.flush && (fill_cnt_q != 3'd0 || xfer))) begin
                    state_d = BUILD;
                end
            end

            BUILD: begin
                for (int i = 0; i < 4; i++) begin
                    for (int j = 0; j < 4; j++) begin
                        raw_d[4*j+i] = (j < i) && valid_q[j] && valid_q[i] &&
                                       ((instr_q[8*j +: 2] == instr_q[8*i+4 +: 2]) ||
                                        (instr_q[8*j +: 2] == instr_q[8*i+2 +: 2]));
                    end
                end
                state_d = RUN;
            end

            RUN: begin
                done_d = done_q | new_ret;
                if (done_d == valid_q) begin
                    windows_d = windows_q + CNT_W'(1);
                    state_d   = CLEAR;
                end else begin
                    wd_d = (new_ret != 4'd0) ? '0 : wd_q + TO_W'(1);
                    if (wd_d == TO_W'(TIMEOUT_CYC)) begin
                        timeout_d = 1'b1;
                        state_d   = CLEAR;
                    end
                end
            end

            CLEAR: begin
                fill_cnt_d = '0;
                instr_d    = '0;
                valid_d    = '0;
                raw_d      = '0;
                done_d     = '0;
                wd_d       = '0;
                state_d    = FILL;
            end

            default: state_d = FILL;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= FILL;
            fill_cnt_q <= '0;
            instr_q    <= '0;
            valid_q    <= '0;
            raw_q      <= '0;
            done_q     <= '0;
            wd_q       <= '0;
            timeout_q  <= 1'b0;
            windows_q  <= '0;
        end else begin
            state_q    <= state_d;
            fill_cnt_q <= fill_cnt_d;
            instr_q    <= instr_d;
            valid_q    <= valid_d;
            raw_q      <= raw_d;
            done_q     <= done_d;
            wd_q       <= wd_d;
            timeout_q  <= timeout_d;
            windows_q  <= windows_d;
        end
    end

endmodule

// File: tb/tb_iq_window_ctrl.sv
// Directed bench for iq_window_ctrl: fill, RAW build, run/retire, watchdog abort,
// flush corner cases and reset during RUN, with hand-computed expectations.
module tb_iq_window_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  retire_onehot;
    logic        sch_enable;
    logic        sched_reset;
    logic [31:0] instr_flat;
    logic [3:0]  valid_bits;
    logic [15:0] raw_flat;
    logic        busy;
    logic        timeout_err;
    logic [15:0] windows_done;

    int checks = 0;
    int errors = 0;

    iq_window_if up ();

    iq_window_ctrl #(.TIMEOUT_CYC(64), .TO_W(7), .CNT_W(16)) dut (
        .clk           (clk),
        .reset         (reset),
        .up            (up),
        .retire_onehot (retire_onehot),
        .sch_enable    (sch_enable),
        .sched_reset   (sched_reset),
        .instr_flat    (instr_flat),
        .valid_bits    (valid_bits),
        .raw_flat      (raw_flat),
        .busy          (busy),
        .timeout_err   (timeout_err),
        .windows_done  (windows_done)
    );

    always #5 clk = ~clk;

    // Control flags packed as {in_ready, sch_enable, sched_reset, busy}.
    function automatic logic [3:0] flags();
        return {up.in_ready, sch_enable, sched_reset, busy};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] instr, input logic fl);
        up.in_valid = 1'b1;
        up.in_instr = instr;
        up.flush    = fl;
        step();
        up.in_valid = 1'b0;
        up.in_instr = 8'h00;
        up.flush    = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        checks++;
        if (flags() !== 4'b1000) begin
            $display("FAIL reset_flags got %b exp %b", flags(), 4'b1000); errors++;
        end
        checks++;
        if ({instr_flat, valid_bits, raw_flat} !== 52'd0) begin
            $display("FAIL reset_window got %h/%h/%h exp 0", instr_flat, valid_bits, raw_flat); errors++;
        end
        checks++;
        if ({timeout_err, windows_done} !== 17'd0) begin
            $display("FAIL reset_status got %b/%0d exp 0/0", timeout_err, windows_done); errors++;
        end
    endtask

    task automatic test_full_window();
        push(8'h01, 1'b0);
        push(8'h12, 1'b0);
        push(8'h83, 1'b0);
        push(8'hC0, 1'b0);
        checks++;
        if (flags() !== 4'b0001) begin
            $display("FAIL t1_build_flags got %b exp %b", flags(), 4'b0001); errors++;
        end
        step();
        checks++;
        if (flags() !== 4'b0101) begin
            $display("FAIL t1_run_flags got %b exp %b", flags(), 4'b0101); errors++;
        end
        checks++;
        if (raw_flat !== 16'h0002) begin
            $display("FAIL t1_raw got %h exp %h", raw_flat, 16'h0002); errors++;
        end
        checks++;
        if ({valid_bits, instr_flat} !== {4'hF, 32'hC083_1201}) begin
            $display("FAIL t1_window got %h/%h exp f/c0831201", valid_bits, instr_flat); errors++;
        end
        retire_onehot = 4'hF;
        step();
        retire_onehot = 4'h0;
        checks++;
        if ({flags(), windows_done} !== {4'b0011, 16'd1}) begin
            $display("FAIL t1_clear got %b/%0d exp 0011/1", flags(), windows_done); errors++;
        end
        step();
        checks++;
        if ({flags(), valid_bits, raw_flat} !== {4'b1000, 4'h0, 16'h0}) begin
            $display("FAIL t1_refill got %b/%h/%h exp 1000/0/0", flags(), valid_bits, raw_flat); errors++;
        end
    endtask

    task automatic test_flush_partial();
        push(8'h05, 1'b0);
        push(8'h36, 1'b0);
        up.flush = 1'b1;
        step();
        up.flush = 1'b0;
        step();
        checks++;
        if ({valid_bits, instr_flat} !== {4'b0011, 32'h0000_3605}) begin
            $display("FAIL t2_window got %h/%h exp 3/00003605", valid_bits, instr_flat); errors++;
        end
        checks++;
        if (raw_flat !== 16'h0002) begin
            $display("FAIL t2_raw got %h exp %h", raw_flat, 16'h0002); errors++;
        end
        retire_onehot = 4'b0001;
        step();
        retire_onehot = 4'b0001;
        step();
        checks++;
        if (flags() !== 4'b0101) begin
            $display("FAIL t2_partial_run got %b exp %b", flags(), 4'b0101); errors++;
        end
        retire_onehot = 4'b0010;
        step();
        retire_onehot = 4'b0000;
        checks++;
        if ({flags(), windows_done} !== {4'b0011, 16'd2}) begin
            $display("FAIL t2_clear got %b/%0d exp 0011/2", flags(), windows_done); errors++;
        end
        step();
    endtask

    task automatic test_ignored_retire();
        push(8'h01, 1'b0);
        push(8'h02, 1'b0);
        up.flush = 1'b1;
        step();
        up.flush = 1'b0;
        step();
        retire_onehot = 4'b1000;
        step();
        checks++;
        if ({flags(), windows_done} !== {4'b0101, 16'd2}) begin
            $display("FAIL t3_empty_retire got %b/%0d exp 0101/2", flags(), windows_done); errors++;
        end
        retire_onehot = 4'b0011;
        step();
        retire_onehot = 4'b1111;
        checks++;
        if ({flags(), windows_done} !== {4'b0011, 16'd3}) begin
            $display("FAIL t3_clear got %b/%0d exp 0011/3", flags(), windows_done); errors++;
        end
        step();
        retire_onehot = 4'b0000;
        checks++;
        if ({flags(), windows_done, valid_bits} !== {4'b1000, 16'd3, 4'h0}) begin
            $display("FAIL t3_pulse_end got %b/%0d/%h exp 1000/3/0", flags(), windows_done, valid_bits); errors++;
        end
    endtask

    task automatic test_timeout();
        push(8'h11, 1'b0);
        push(8'h22, 1'b0);
        push(8'h33, 1'b0);
        push(8'h44, 1'b0);
        step();
        for (int n = 0; n < 63; n++) step();
        checks++;
        if ({flags(), timeout_err} !== {4'b0101, 1'b0}) begin
            $display("FAIL t4_before_limit got %b/%b exp 0101/0", flags(), timeout_err); errors++;
        end
        step();
        checks++;
        if ({flags(), timeout_err, windows_done} !== {4'b0011, 1'b1, 16'd3}) begin
            $display("FAIL t4_abort got %b/%b/%0d exp 0011/1/3", flags(), timeout_err, windows_done); errors++;
        end
        step();
        checks++;
        if ({flags(), timeout_err, valid_bits} !== {4'b1000, 1'b1, 4'h0}) begin
            $display("FAIL t4_back_to_fill got %b/%b/%h exp 1000/1/0", flags(), timeout_err, valid_bits); errors++;
        end
    endtask

    task automatic test_flush_corners();
        up.flush = 1'b1;
        step();
        up.flush = 1'b0;
        checks++;
        if ({flags(), valid_bits} !== {4'b1000, 4'h0}) begin
            $display("FAIL t5_empty_flush got %b/%h exp 1000/0", flags(), valid_bits); errors++;
        end
        push(8'h07, 1'b1);
        checks++;
        if (flags() !== 4'b0001) begin
            $display("FAIL t5_coincident_build got %b exp %b", flags(), 4'b0001); errors++;
        end
        step();
        checks++;
        if ({valid_bits, instr_flat, raw_flat, timeout_err} !== {4'b0001, 32'h7, 16'h0, 1'b1}) begin
            $display("FAIL t5_window got %h/%h/%h/%b exp 1/00000007/0000/1",
                     valid_bits, instr_flat, raw_flat, timeout_err); errors++;
        end
        retire_onehot = 4'b0001;
        step();
        retire_onehot = 4'b0000;
        step();
        checks++;
        if ({flags(), windows_done} !== {4'b1000, 16'd4}) begin
            $display("FAIL t5_done got %b/%0d exp 1000/4", flags(), windows_done); errors++;
        end
    endtask

    task automatic test_reset_in_run();
        push(8'h01, 1'b0);
        push(8'h12, 1'b0);
        push(8'h83, 1'b0);
        push(8'hC0, 1'b0);
        step();
        checks++;
        if (flags() !== 4'b0101) begin
            $display("FAIL t6_in_run got %b exp %b", flags(), 4'b0101); errors++;
        end
        reset = 1'b1;
        step();
        checks++;
        if ({flags(), valid_bits, raw_flat, instr_flat} !== {4'b1000, 4'h0, 16'h0, 32'h0}) begin
            $display("FAIL t6_reset got %b/%h/%h/%h exp 1000/0/0/0", flags(), valid_bits, raw_flat, instr_flat); errors++;
        end
        checks++;
        if ({timeout_err, windows_done} !== 17'd0) begin
            $display("FAIL t6_status got %b/%0d exp 0/0", timeout_err, windows_done); errors++;
        end
        reset = 1'b0;
        step();
    endtask

    initial begin
        reset         = 1'b1;
        retire_onehot = 4'h0;
        up.in_valid   = 1'b0;
        up.in_instr   = 8'h00;
        up.flush      = 1'b0;
        test_reset();
        test_full_window();
        test_flush_partial();
        test_ignored_retire();
        test_timeout();
        test_flush_corners();
        test_reset_in_run();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
